// File: rtl/transposer_buf_responder.sv
// Scratchpad stand-in for the transposer: fixed-latency line reads, line writes,
// host preload, transaction counters and sticky error flags.
module transposer_buf_responder #(
    parameter int AW     = 16,
    parameter int BUFFD  = 64,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AW-1:0]        raddr,
    input  logic                 raddr_vld,
    output logic [BUFFD*8-1:0]   rdata,
    output logic                 rdata_vld,
    input  logic [AW-1:0]        waddr,
    input  logic [BUFFD*8-1:0]   wdata,
    input  logic                 wdata_vld,
    input  logic [AW-1:0]        ld_addr,
    input  logic [BUFFD*8-1:0]   ld_data,
    input  logic                 ld_vld,
    input  logic                 cnt_clr,
    output logic [AW-1:0]        rd_cnt,
    output logic [AW-1:0]        wr_cnt,
    output logic [1:0]           err
);
    localparam int DW = BUFFD * 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    logic [DW-1:0] mem_r [DEPTH];
    logic [RD_LAT-1:0] pipe_vld_r;
    logic [DW-1:0]     pipe_data_r [RD_LAT];
    logic [AW-1:0]     rd_cnt_r;
    logic [AW-1:0]     wr_cnt_r;
    logic [1:0]        err_r;

    logic          rd_in_s;
    logic          wr_ok_s;
    logic          ld_ok_s;
    logic          collide_s;
    logic          ld_commit_s;
    logic          oor_s;
    logic [DW-1:0] rd_line_s;
    logic [AW-1:0] rd_cnt_nxt_s;
    logic [AW-1:0] wr_cnt_nxt_s;
    logic [1:0]    err_nxt_s;

    // Strobe qualification: range checks and same-address write/preload collision
    always_comb begin
        rd_in_s     = in_range(raddr);
        wr_ok_s     = wdata_vld & in_range(waddr);
        ld_ok_s     = ld_vld & in_range(ld_addr);
        collide_s   = ld_vld & wdata_vld & (ld_addr == waddr);
        ld_commit_s = ld_ok_s & ~collide_s;
        oor_s       = (raddr_vld & ~rd_in_s)
                    | (wdata_vld & ~in_range(waddr))
                    | (ld_vld & ~in_range(ld_addr));
    end

    // Read line as it will stand after this edge's commits (write beats preload)
    always_comb begin
        rd_line_s = {DW{1'b0}};
        if (!rd_in_s) begin
            rd_line_s = {DW{1'b0}};
        end else if (wr_ok_s && (waddr == raddr)) begin
            rd_line_s = wdata;
        end else if (ld_commit_s && (ld_addr == raddr)) begin
            rd_line_s = ld_data;
        end else begin
            rd_line_s = mem_r[raddr[IW-1:0]];
        end
    end

    // Line storage; deliberately not reset so contents survive reset_n
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[waddr[IW-1:0]] <= wdata;
        end
        if (ld_commit_s) begin
            mem_r[ld_addr[IW-1:0]] <= ld_data;
        end
    end

    // Read pipeline; data stages load only behind a valid so rdata holds when idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_r[i] <= {DW{1'b0}};
            end
        end else begin
            pipe_vld_r[0] <= raddr_vld;
            if (raddr_vld) begin
                pipe_data_r[0] <= rd_line_s;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                if (pipe_vld_r[i-1]) begin
                    pipe_data_r[i] <= pipe_data_r[i-1];
                end
            end
        end
    end

    // Counter and flag next-state: a clear still lets this cycle's events land
    always_comb begin
        rd_cnt_nxt_s = rd_cnt_r;
        wr_cnt_nxt_s = wr_cnt_r;
        err_nxt_s    = err_r;
        if (cnt_clr) begin
            rd_cnt_nxt_s = {AW{1'b0}};
            wr_cnt_nxt_s = {AW{1'b0}};
            err_nxt_s    = 2'b00;
        end else begin
            rd_cnt_nxt_s = rd_cnt_r;
            wr_cnt_nxt_s = wr_cnt_r;
            err_nxt_s    = err_r;
        end
        rd_cnt_nxt_s = rd_cnt_nxt_s + {{(AW-1){1'b0}}, raddr_vld};
        wr_cnt_nxt_s = wr_cnt_nxt_s + {{(AW-1){1'b0}}, wr_ok_s};
        err_nxt_s    = err_nxt_s | {collide_s, oor_s};
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_r <= {AW{1'b0}};
            wr_cnt_r <= {AW{1'b0}};
            err_r    <= 2'b00;
        end else begin
            rd_cnt_r <= rd_cnt_nxt_s;
            wr_cnt_r <= wr_cnt_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    assign rdata     = pipe_data_r[RD_LAT-1];
    assign rdata_vld = pipe_vld_r[RD_LAT-1];
    assign rd_cnt    = rd_cnt_r;
    assign wr_cnt    = wr_cnt_r;
    assign err       = err_r;

endmodule

// File: doc/transposer_buf_responder.md
Name: transposer_buf_responder

Overview:
- Buffer-side responder for the transposer read/write address interface: serves `raddr`/`raddr_vld` requests with `rdata`/`rdata_vld` after a fixed latency, and commits `waddr`/`wdata`/`wdata_vld` writes.
- Holds DEPTH lines of BUFFD bytes.
- Adds a host preload port, transaction counters and sticky error flags so simulation and FPGA benches can stand in for the real scratchpad.

Parameters:
- AW, 16, address width (matches the transposer).
- BUFFD, 64, bytes per line; data width is BUFFD*8.
- DEPTH, 1024, number of lines; valid addresses are 0..DEPTH-1.
- RD_LAT, 2, read latency in cycles; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- raddr  in  AW  read line address.
- raddr_vld  in  1  read request strobe; one request per cycle, no backpressure.
- rdata  out  BUFFD*8  read data.
- rdata_vld  out  1  read data valid.
- waddr  in  AW  write line address.
- wdata  in  BUFFD*8  write data.
- wdata_vld  in  1  write strobe.
- ld_addr  in  AW  host preload address.
- ld_data  in  BUFFD*8  host preload data.
- ld_vld  in  1  host preload strobe.
- cnt_clr  in  1  synchronous clear of counters and error flags.
- rd_cnt  out  AW  accepted read requests since reset or clear.
- wr_cnt  out  AW  committed writes since reset or clear.
- err  out  2  sticky flags: [0] out-of-range access, [1] preload collision.

Behaviour:
- Reset (async assert, sync release):
  - rdata=0, rdata_vld=0, rd_cnt=0, wr_cnt=0, err=0.
  - Read pipeline valid bits cleared; in-flight reads are dropped.
  - Memory array is not reset; contents are preserved across reset.
- Read pipeline:
  - A request sampled at cycle T with in-range raddr produces rdata_vld=1 at T+RD_LAT, with data as the line stood at the end of cycle T.
  - Same-cycle write to the same address is forwarded (write-first): the read returns the new wdata.
  - Writes in cycles T+1..T+RD_LAT do not affect that read's data.
  - Back-to-back requests give back-to-back responses, in order.
  - rdata holds its last value when rdata_vld=0.
- Write:
  - wdata_vld with in-range waddr updates the line at the clock edge.
  - wr_cnt increments by 1.
- Preload:
  - ld_vld with in-range ld_addr updates the line at the edge. Preloads do not count in wr_cnt.
  - If ld_vld and wdata_vld occur in the same cycle with the same address: wdata wins, the preload is dropped, err[1] is set.
  - Different addresses in the same cycle: both commit.
  - A same-cycle read to a preloaded address forwards the winning data.
- Out-of-range (address >= DEPTH) on any strobe:
  - Sets err[0].
  - A write or preload is ignored.
  - A read still responds at T+RD_LAT with rdata=0 and rdata_vld=1, so the requester's count stays aligned.
- Counters:
  - rd_cnt increments on every raddr_vld, in range or not. wr_cnt counts in-range wdata writes only.
  - Both wrap modulo 2^AW.
- cnt_clr: clears rd_cnt, wr_cnt and err at the edge.
  - An event in the same cycle as cnt_clr results in a count of 1, not 0.
  - A simultaneous error leaves its flag set.
  - cnt_clr does not touch the read pipeline or memory.
- Internals: no FSM beyond the RD_LAT-stage valid/address/data shift pipeline; memory indexed by the low clog2(DEPTH) address bits after the range check.

Test Plan:
- Preload lines 0..3 with the byte pattern addr*16+byte; issue reads 0,1,2,3 back-to-back from cycle 10 with RD_LAT=2 -> rdata_vld high on cycles 12..15, data matching in order, rd_cnt=4.
- Write line 5 = all 0xAA and read line 5 in the same cycle -> response 2 cycles later is 0xAA (forwarding); read line 5 at T and write 0x55 at T+1 -> response is 0xAA.
- Drive ld_vld and wdata_vld both to address 7 with data 0x11 and 0x22 respectively -> line 7 = 0x22, err=2'b10, wr_cnt +1.
- Read address 1024 with DEPTH=1024 -> rdata=0 with rdata_vld=1 at T+2 and err[0]=1; a write to 2000 leaves memory unchanged and wr_cnt unchanged.
- Issue 3 reads, then assert reset_n low mid-flight for 1 cycle -> no rdata_vld after reset, counters 0, earlier-written lines still readable.
- Assert cnt_clr in the same cycle as a read -> rd_cnt=1 next cycle; 65536 reads with AW=16 -> rd_cnt wraps to 0.
